// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: IF fetch handshake, inst-SRAM response, ID head, flush.
// master = IF/ID side driving fetch/flush/out_ready; slave = the queue.
interface inst_fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              fetch_fire;
    logic [PC_W-1:0]   fetch_pc;
    logic [INST_W-1:0] inst_sram_rdata;
    logic              fetch_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic              flush;
    logic              ds_keep;
    logic [CNT_W-1:0]  count;

    modport master (
        output fetch_fire, fetch_pc, inst_sram_rdata,
        output out_ready, flush, ds_keep,
        input  fetch_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  fetch_fire, fetch_pc, inst_sram_rdata,
        input  out_ready, flush, ds_keep,
        output fetch_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// IF->ID instruction buffer: captures the 1-cycle SRAM response into a
// DEPTH-entry {pc,inst} ring; ports: clk, rst (async high), bus (slave).
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input logic              clk,
    input logic              rst,
    inst_fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = PC_W + INST_W;

    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_v_q, pend_v_d;
    logic [PC_W-1:0]  pend_pc_q, pend_pc_d;

    logic             push, pop, wr_en;
    logic [CNT_W-1:0] remain;
    logic [PTR_W-1:0] keep_idx;

    assign push = pend_v_q;
    assign pop  = bus.out_valid && bus.out_ready;

    // Entries surviving this cycle's pop; the oldest one sits at keep_idx.
    assign remain   = count_q - CNT_W'(pop);
    assign keep_idx = head_q + PTR_W'(pop);

    always_comb begin
        head_d    = head_q + PTR_W'(pop);
        tail_d    = tail_q + PTR_W'(push);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        pend_v_d  = bus.fetch_fire;
        pend_pc_d = bus.fetch_fire ? bus.fetch_pc : pend_pc_q;
        wr_en     = push;

        if (bus.flush) begin
            pend_v_d = 1'b0;
            wr_en    = 1'b0;
            if (!bus.ds_keep) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else if (remain != '0) begin
                // Oldest queued entry becomes the lone delay slot.
                head_d  = keep_idx;
                tail_d  = keep_idx + PTR_W'(1);
                count_d = CNT_W'(1);
            end else if (push) begin
                wr_en   = 1'b1;
                head_d  = tail_q;
                tail_d  = tail_q + PTR_W'(1);
                count_d = CNT_W'(1);
            end else begin
                // Delay slot is still in flight: let its response land.
                head_d   = tail_q;
                tail_d   = tail_q;
                count_d  = '0;
                pend_v_d = bus.fetch_fire;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Array content is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= {pend_pc_q, bus.inst_sram_rdata};
        end
    end

    // Ignores a same-cycle pop so fetch_ready stays purely registered;
    // an in-flight response therefore always finds a free slot.
    assign bus.fetch_ready =
        ({1'b0, count_q} + (CNT_W + 1)'(pend_v_q)) < (CNT_W + 1)'(DEPTH);

    assign bus.out_valid = (count_q != '0);
    assign {bus.out_pc, bus.out_inst} = mem_q[head_q];
    assign bus.count = count_q;
endmodule
